// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake between a producer and the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first frames sent back-to-back on TXD.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                               CLK100MHZ,
  input  logic                               reset_n,
  uart_tx_fifo_if.slave                      bus,
  output logic                               TXD,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

  logic parity_r;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  baud_tick_s;
  logic                  stop_end_s;
  logic [DATA_WIDTH-1:0] head_s;

  state_t                state_r;
  logic [BAUD_W-1:0]     baud_r;
  logic [BIT_W-1:0]      bit_idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  txd_r;
  logic                  busy_r;
  logic                  done_r;

  assign full_s       = (count_r == COUNT_FULL);
  assign empty_s      = (count_r == '0);
  assign push_s       = bus.tx_valid & ~full_s;
  assign head_s       = mem_r[rd_ptr_r];
  assign bus.tx_ready = ~full_s;
  assign TXD          = txd_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign fifo_count   = count_r;

  // Pop a word when a frame starts from IDLE or chains directly off an expiring stop bit
  always_comb begin
    baud_tick_s = (baud_r == BAUD_LAST);
    stop_end_s  = (state_r == STOP) && baud_tick_s && (bit_idx_r == STOP_LAST);
    if (empty_s) begin
      pop_s = 1'b0;
    end else if (state_r == IDLE) begin
      pop_s = 1'b1;
    end else if (stop_end_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Word buffer: circular storage, wrapping pointers and occupancy count
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.tx_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencer; the baud counter restarts on every state entry and bit boundary
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_idx_r <= '0;
      shift_r   <= '0;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_r    <= '0;
          bit_idx_r <= '0;
          if (pop_s) begin
            shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_of(head_s, 1'(PARITY_ODD));
`endif
            txd_r    <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= START;
          end else begin
            txd_r  <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (baud_tick_s) begin
            baud_r    <= '0;
            bit_idx_r <= '0;
            txd_r     <= shift_r[0];
            shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
            state_r   <= DATA;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_tick_s) begin
            baud_r <= '0;
            if (bit_idx_r == DATA_LAST) begin
              bit_idx_r <= '0;
`ifdef UART_TX_PARITY_EN
              txd_r     <= parity_r;
              state_r   <= PARITY;
`else
              txd_r     <= 1'b1;
              state_r   <= STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + BIT_W'(1);
              txd_r     <= shift_r[0];
              shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick_s) begin
            baud_r    <= '0;
            bit_idx_r <= '0;
            txd_r     <= 1'b1;
            state_r   <= STOP;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_tick_s) begin
            baud_r <= '0;
            if (bit_idx_r == STOP_LAST) begin
              bit_idx_r <= '0;
              done_r    <= 1'b1;
              // Chain the next frame straight into START so no idle bit appears
              if (pop_s) begin
                shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
                parity_r <= parity_of(head_s, 1'(PARITY_ODD));
`endif
                txd_r    <= 1'b0;
                busy_r   <= 1'b1;
                state_r  <= START;
              end else begin
                txd_r   <= 1'b1;
                busy_r  <= 1'b0;
                state_r <= IDLE;
              end
            end else begin
              bit_idx_r <= bit_idx_r + BIT_W'(1);
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          baud_r    <= '0;
          bit_idx_r <= '0;
          txd_r     <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed steps plus random traffic against a
// frame-level reference model (word queue + per-frame bit list).
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int FLEN = (1 + DW + PB + SB) * CPB;
  localparam int CW   = $clog2(DEPTH + 1);

  logic          CLK100MHZ = 1'b0;
  logic          reset_n;
  logic          TXD;
  logic          busy;
  logic          done;
  logic [CW-1:0] fifo_count;

  uart_tx_fifo_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_fifo #(
    .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB),
    .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .reset_n(reset_n), .bus(bus),
    .TXD(TXD), .busy(busy), .done(done), .fifo_count(fifo_count)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] src[$];
  logic          fb[$];
  bit            gate = 1'b0;
  bit            in_flight = 1'b0;
  int            t = 0;
  bit            exp_done = 1'b0;
  int            accept_cyc = 0;
  int            done_cycles[$];
  int            max_cnt_seen = 0;
  bit            saw_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels for one frame: start, data LSB first, optional parity, stop bits
  function automatic void build_frame(input logic [DW-1:0] w);
    fb.delete();
    fb.push_back(1'b0);
    for (int i = 0; i < DW; i++) fb.push_back(w[i]);
    if (PB == 1) fb.push_back(logic'((($countones(w) + PODD) % 2) != 0));
    for (int i = 0; i < SB; i++) fb.push_back(1'b1);
  endfunction

  task automatic drive_producer();
    bus.tx_valid = gate && (src.size() > 0);
    bus.tx_data  = (src.size() > 0) ? src[0] : '0;
  endtask

  task automatic step();
    bit            do_push;
    int            pre_size;
    logic [DW-1:0] wd;
    pre_size = mq.size();
    do_push  = bus.tx_valid && (pre_size < DEPTH);
    wd       = bus.tx_data;
    @(posedge CLK100MHZ);
    cyc++;
    exp_done = 1'b0;
    if (in_flight) begin
      t++;
      if (t == FLEN) begin
        exp_done  = 1'b1;
        in_flight = 1'b0;
      end
    end
    if (!in_flight && pre_size > 0) begin
      build_frame(mq.pop_front());
      in_flight = 1'b1;
      t = 0;
    end
    if (do_push) begin
      mq.push_back(wd);
      void'(src.pop_front());
      accept_cyc = cyc;
    end
    @(negedge CLK100MHZ);
    check("txd", 32'(TXD), 32'(in_flight ? fb[t / CPB] : 1'b1));
    check("busy", 32'(busy), 32'(in_flight));
    check("done", 32'(done), 32'(exp_done));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("tx_ready", 32'(bus.tx_ready), 32'(mq.size() < DEPTH));
    if (done === 1'b1) done_cycles.push_back(cyc);
    if (int'(fifo_count) > max_cnt_seen) max_cnt_seen = int'(fifo_count);
    if (bus.tx_valid && !bus.tx_ready) saw_stall = 1'b1;
    drive_producer();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((in_flight || mq.size() > 0 || src.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    n_assert++;
    assert (n < max_cycles) else begin
      n_fail++;
      $error("FAIL timeout observed=%0d cycles expected<%0d", n, max_cycles);
    end
  endtask

  task automatic wait_frame_pos(input int pos, input int max_cycles);
    int n = 0;
    while (!(in_flight && t == pos) && n < max_cycles) begin
      step();
      n++;
    end
    n_assert++;
    assert (n < max_cycles) else begin
      n_fail++;
      $error("FAIL wait_pos observed=%0d cycles expected<%0d", n, max_cycles);
    end
  endtask

  initial begin
    logic [DW-1:0] w;
    reset_n      = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge CLK100MHZ);
    reset_n = 1'b1;

    // Reset state, then a long idle stretch
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    repeat (50) step();

    // Single word 0xA5: done lands FLEN+1 edges after acceptance
    done_cycles.delete();
    gate = 1'b1;
    src.push_back(8'hA5);
    drive_producer();
    run_until_idle(200);
    check("single_ndone", 32'(done_cycles.size()), 32'd1);
    if (done_cycles.size() == 1) check("single_done_lat", 32'(done_cycles[0] - accept_cyc), 32'(FLEN + 1));

    // Six words with tx_valid held: FIFO fills, producer stalls, frames chain
    done_cycles.delete();
    max_cnt_seen = 0;
    saw_stall = 1'b0;
    src.push_back(8'h00); src.push_back(8'hFF); src.push_back(8'h55);
    src.push_back(8'hAA); src.push_back(8'h0F); src.push_back(8'hF0);
    drive_producer();
    run_until_idle(1000);
    check("burst_maxcnt", 32'(max_cnt_seen), 32'(DEPTH));
    check("burst_stall", 32'(saw_stall), 32'd1);
    check("burst_ndone", 32'(done_cycles.size()), 32'd6);
    for (int i = 1; i < done_cycles.size(); i++)
      check("burst_spacing", 32'(done_cycles[i] - done_cycles[i-1]), 32'(FLEN));

`ifdef UART_TX_PARITY_EN
    // Parity on 0x07: three ones, so the parity bit carries the even/odd sense
    done_cycles.delete();
    src.push_back(8'h07);
    drive_producer();
    wait_frame_pos((1 + DW) * CPB, 100);
    check("parity_bit", 32'(TXD), 32'(PODD == 0 ? 1 : 0));
    run_until_idle(200);
    check("parity_len", 32'(done_cycles[0] - accept_cyc), 32'(FLEN + 1));
`endif

    // Reset during data bit 3 of 0xF0 with two words queued
    done_cycles.delete();
    src.push_back(8'hF0);
    src.push_back(DW'($urandom));
    src.push_back(DW'($urandom));
    drive_producer();
    wait_frame_pos(4 * CPB + 1, 200);
    check("pre_rst_txd", 32'(TXD), 32'd0);
    gate = 1'b0;
    drive_producer();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_txd", 32'(TXD), 32'd1);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    mq.delete();
    src.delete();
    in_flight = 1'b0;
    @(negedge CLK100MHZ);
    reset_n = 1'b1;
    repeat (5) step();
    check("midrst_nodone", 32'(done_cycles.size()), 32'd0);
    gate = 1'b1;
    src.push_back(DW'($urandom));
    drive_producer();
    run_until_idle(200);
    check("postrst_ndone", 32'(done_cycles.size()), 32'd1);

    // Simultaneous push and pop at count 2
    for (int i = 0; i < 3; i++) src.push_back(DW'($urandom));
    drive_producer();
    while (src.size() > 0) step();
    wait_frame_pos(FLEN - 1, 200);
    check("pp_pre_count", 32'(fifo_count), 32'd2);
    src.push_back(DW'($urandom));
    drive_producer();
    step();
    check("pp_count", 32'(fifo_count), 32'd2);
    run_until_idle(1000);

    // Random words with random producer gaps
    for (int i = 0; i < 10; i++) src.push_back(DW'($urandom));
    for (int n = 0; n < 3000 && src.size() > 0; n++) begin
      gate = ($urandom_range(0, 3) != 0);
      step();
    end
    gate = 1'b1;
    drive_producer();
    run_until_idle(1000);
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter: accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first as 8N1-style frames with configurable data width, stop-bit count and baud divisor. Frames go out back-to-back with no idle gap while the FIFO holds data. Optional parity is selected at compile time. It sits between the system logic in the CLK100MHZ domain and the board TXD pin, replacing the single-word, level-enabled transmitter.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- CLKS_PER_BIT, 868, CLK100MHZ cycles per bit (115200 baud at 100 MHz); ≥ 2
- STOP_BITS, 1, number of stop bits (1 or 2)
- FIFO_DEPTH, 4, word buffer depth; power of two, ≥ 2
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd
- CLK100MHZ  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- tx_valid  in  1  tx_data is valid this cycle
- tx_data  in  DATA_WIDTH  word to transmit
- tx_ready  out  1  FIFO can accept a word (= !full)
- TXD  out  1  serial line, idle high
- busy  out  1  a frame is on the line
- done  out  1  one-cycle pulse at the end of each frame
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words buffered, not counting the word in flight

## Operation
- Push: when tx_valid && tx_ready at a rising edge, tx_data is written to the FIFO. tx_valid while !tx_ready is ignored, and the producer holds the data.
- tx_ready depends only on FIFO state. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
- Push and pop in the same cycle with the FIFO not full: the count is unchanged and both take effect.
- Read/write pointers wrap modulo FIFO_DEPTH. The count saturates at neither end; the full and empty flags prevent over- and underflow.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE → START: the FIFO is not empty. The word is popped into the shift register and TXD is driven to 0.
- START → DATA: after CLKS_PER_BIT cycles. Bit 0 is driven first.
- DATA → DATA: shift each CLKS_PER_BIT cycles. After DATA_WIDTH bits, go to PARITY if compiled in, else STOP.
- PARITY → STOP: after one bit time, with TXD = 1.
- STOP: lasts STOP_BITS × CLKS_PER_BIT cycles.
  - At expiry, done pulses.
  - If the FIFO is not empty, the next word is popped and the FSM goes directly to START with no idle bit.
  - Otherwise the FSM goes to IDLE.
- Baud counter: cleared on every state entry and on each bit boundary, so it is phase-locked to the frame start and never free-running. Width $clog2(CLKS_PER_BIT).
- busy is high in every state except IDLE.

## Timing
- Reset values:
  - Outputs: TXD = 1, tx_ready = 1, busy = 0, done = 0, fifo_count = 0.
  - Internal: FSM in IDLE, pointers 0.
- Reset mid-frame: TXD returns high asynchronously, the FIFO contents and the frame in flight are discarded, and done is not asserted.
- Latency: a word accepted at edge k into an empty FIFO with the FSM in IDLE drives TXD low at edge k+1. fifo_count reads 1 for exactly one cycle.
- Every bit on TXD lasts exactly CLKS_PER_BIT cycles. There are no glitches, because TXD is registered.
- Frame length: (1 + DATA_WIDTH + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.
- done is high for one cycle, coincident with the first cycle after the last stop bit. Back-to-back frames: that same cycle is the first START cycle of the next frame.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: a parity bit follows the data bits. Its value is the XOR of the data bits, inverted when PARITY_ODD = 1. It is computed from the popped word at load time.
  - Undefined: there is no PARITY state or logic, and PARITY_ODD is ignored.

## Test plan
- Reset, then idle 50 cycles → TXD = 1, busy = 0, tx_ready = 1, fifo_count = 0. No parity, CLKS_PER_BIT = 4, DATA_WIDTH = 8, STOP_BITS = 1.
- Single push of 0xA5 at edge k, no parity → TXD pattern 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit, starting at edge k+1. done pulses at k+41, and busy falls the same cycle.
- Push 6 words (0x00, 0xFF, 0x55, 0xAA, 0x0F, 0xF0) holding tx_valid, FIFO_DEPTH = 4:
  - tx_ready drops when fifo_count = 4, and the producer stalls until a pop.
  - All 6 frames go out back-to-back with no idle bit between them.
  - 6 done pulses, spaced 40 cycles apart.
- Parity compiled in with STOP_BITS = 2:
  - 0x07 with PARITY_ODD = 0 → parity bit 1 and a 48-cycle frame.
  - 0x07 with PARITY_ODD = 1 → parity bit 0.
- Assert reset_n low during DATA bit 3 → TXD = 1 immediately, fifo_count = 0, no done pulse. After release, a new push transmits a correct frame.
- Push and pop in the same cycle at fifo_count = 2 → count stays 2. Write data is preserved and transmitted in order.
